data_mem_mmio: RTL and testbench

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

---
 rtl/data_mem_mmio.sv | 231 +++++++++++++++++++++++
 tb/tb_data_mem_mmio.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// Data RAM plus memory-mapped peripherals: reload timers, LED/display registers,
// a free-running SYSTICK and a multiplexed seven-segment scanner.

module data_mem_mmio_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_wr_th,
  input  logic        i_wr_tl,
  input  logic        i_wr_tcon,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic        o_run,
  output logic        o_ien,
  output logic        o_st
);
  logic [31:0] r_th, r_tl;
  logic        r_run, r_ien, r_st;
  logic        w_wrap;

  assign w_wrap = r_run && i_en && (&r_tl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_th  <= '0;
      r_tl  <= '0;
      r_run <= 1'b0;
      r_ien <= 1'b0;
      r_st  <= 1'b0;
    end else begin
      if (i_wr_th) r_th <= i_wdata;
      // software TL write beats the counter's own increment/reload
      if (i_wr_tl)              r_tl <= i_wdata;
      else if (r_run && i_en)   r_tl <= w_wrap ? r_th : r_tl + 32'd1;
      if (i_wr_tcon) begin
        r_run <= i_wdata[0];
        r_ien <= i_wdata[1];
      end
      // a reload sets status even if the same cycle carries a W1C clear
      if (w_wrap)                         r_st <= 1'b1;
      else if (i_wr_tcon && i_wdata[2])   r_st <= 1'b0;
    end
  end

  assign o_th  = r_th;
  assign o_tl  = r_tl;
  assign o_run = r_run;
  assign o_ien = r_ien;
  assign o_st  = r_st;
endmodule

module data_mem_mmio #(
  parameter int RAM_DEPTH  = 512,
  parameter int NUM_TIMERS = 2,
  parameter int LED_W      = 7,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_en,
  input  logic                  wr_en,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  irq,
  output logic [NUM_TIMERS-1:0] irq_vec,
  output logic [LED_W-1:0]      leds_o,
  output logic [6:0]            seg_o,
  output logic [DIGITS-1:0]     an_o
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = 4 * DIGITS;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [31:0]           r_ram [RAM_DEPTH];
  logic                  r_active;
  logic [LED_W-1:0]      r_led;
  logic [DW-1:0]         r_disp;
  logic [31:0]           r_systick;
  logic [PW-1:0]         r_pre;
  logic [IW-1:0]         r_idx;
  logic [DIGITS-1:0]     r_an;
  logic [6:0]            r_seg;

  logic                  w_wr, w_ram_sel, w_tpage, w_mpage;
  logic [AW-1:0]         w_widx;
  logic [1:0]            w_off;
  logic [NUM_TIMERS-1:0] w_tsel;
  logic [NUM_TIMERS-1:0][31:0] w_th, w_tl;
  logic [NUM_TIMERS-1:0] w_run, w_ien, w_st;
  logic [3:0]            w_nib;
  logic                  w_unused;

  // address decode; the edge that releases reset only arms r_active
  assign w_wr      = mem_en && wr_en && r_active;
  assign w_ram_sel = (addr[31:30] == 2'b00);
  assign w_tpage   = (addr[31:8] == 24'h400000);
  assign w_mpage   = (addr[31:8] == 24'h400001);
  assign w_widx    = addr[AW+1:2];
  assign w_off     = addr[3:2];
  assign w_unused  = ^{addr[1:0], addr[29:AW+2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_active <= 1'b0;
    else        r_active <= 1'b1;
  end

  // RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (w_wr && w_ram_sel) r_ram[w_widx] <= wdata;
  end

  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_tmr
    assign w_tsel[k] = w_wr && w_tpage && (addr[7:4] == 4'(k));

    data_mem_mmio_timer u_tmr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (r_active),
      .i_wr_th   (w_tsel[k] && (w_off == 2'd0)),
      .i_wr_tl   (w_tsel[k] && (w_off == 2'd1)),
      .i_wr_tcon (w_tsel[k] && (w_off == 2'd2)),
      .i_wdata   (wdata),
      .o_th      (w_th[k]),
      .o_tl      (w_tl[k]),
      .o_run     (w_run[k]),
      .o_ien     (w_ien[k]),
      .o_st      (w_st[k])
    );

    assign irq_vec[k] = w_ien[k] & w_st[k];
  end

  assign irq = |irq_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led     <= '0;
      r_disp    <= '0;
      r_systick <= '0;
    end else begin
      if (w_wr && w_mpage && (addr[7:2] == 6'd0)) r_led  <= wdata[LED_W-1:0];
      if (w_wr && w_mpage && (addr[7:2] == 6'd1)) r_disp <= wdata[DW-1:0];
      if (r_active) r_systick <= r_systick + 32'd1;
    end
  end

  // digit scan: prescaler terminal count advances the digit slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_active) begin
      if (r_pre == PRE_MAX) begin
        r_pre <= '0;
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_nib = r_disp[r_idx*4 +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= ~DIGITS'(1);
      r_seg <= 7'h40;
    end else begin
      r_an  <= ~(DIGITS'(1) << r_idx);
      r_seg <= hex7(w_nib);
    end
  end

  assign an_o   = r_an;
  assign seg_o  = r_seg;
  assign leds_o = r_led;

  always_comb begin
    rdata = '0;
    if (mem_en) begin
      if (w_ram_sel) begin
        rdata = r_ram[w_widx];
      end else if (w_tpage) begin
        for (int k = 0; k < NUM_TIMERS; k++) begin
          if (addr[7:4] == 4'(k)) begin
            case (w_off)
              2'd0:    rdata = w_th[k];
              2'd1:    rdata = w_tl[k];
              2'd2:    rdata = {29'd0, w_st[k], w_ien[k], w_run[k]};
              default: rdata = '0;
            endcase
          end
        end
      end else if (w_mpage) begin
        case (addr[7:2])
          6'd0:    rdata = 32'(r_led);
          6'd1:    rdata = 32'(r_disp);
          6'd2:    rdata = r_systick;
          default: rdata = '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: the driver queues expectations, a negedge
// monitor drains the queue against the live outputs.
module tb_data_mem_mmio;
  localparam int NT = 2;
  localparam int LW = 7;
  localparam int DG = 4;

  logic          clk = 1'b0, rst_n = 1'b0, mem_en = 1'b0, wr_en = 1'b0;
  logic [31:0]   addr = '0, wdata = '0, rdata;
  logic          irq;
  logic [NT-1:0] irq_vec;
  logic [LW-1:0] leds_o;
  logic [6:0]    seg_o;
  logic [DG-1:0] an_o;

  data_mem_mmio #(.RAM_DEPTH(512), .NUM_TIMERS(NT), .LED_W(LW), .DIGITS(DG), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .irq_vec(irq_vec), .leds_o(leds_o), .seg_o(seg_o), .an_o(an_o)
  );

  always #5 clk = ~clk;

  typedef struct { int sel; logic [31:0] exp; string name; } chk_t;
  chk_t q[$];
  int checks = 0, errors = 0;

  function automatic logic [31:0] act(int sel);
    case (sel)
      0:       return rdata;
      1:       return {31'd0, irq};
      2:       return 32'(irq_vec);
      3:       return 32'(leds_o);
      4:       return 32'(seg_o);
      default: return 32'(an_o);
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] a;
      c = q.pop_front();
      a = act(c.sel);
      checks++;
      if (a !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", c.name, a, c.exp);
      end
    end
  end

  task automatic push(input int sel, input logic [31:0] e, input string n);
    chk_t c;
    c.sel = sel; c.exp = e; c.name = n;
    q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_en = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    step();
    mem_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wr_chk(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e, input string n);
    mem_en = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    push(0, e, n);
    step();
    mem_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    mem_en = 1'b1; wr_en = 1'b0; addr = a;
    push(0, e, n);
    step();
    mem_en = 1'b0;
  endtask

  // bounded wait for an_o to become (eq=1) or leave (eq=0) a given value
  task automatic wait_an(input logic [DG-1:0] v, input bit eq, input string n);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if ((an_o == v) == eq) hit = 1'b1;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL %s: got an_o %b after 40 cycles want %s %b", n, an_o, eq ? "==" : "!=", v);
    end
  endtask

  logic [3:0] an_tab [4];
  logic [6:0] seg_tab [4];

  initial begin
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{7'h0E, 7'h30, 7'h08, 7'h79};   // F, 3, A, 1

    // reset state
    step();
    push(5, 32'hE, "an_rst");
    push(4, 32'h40, "seg_rst");
    push(1, 32'h0, "irq_rst");
    push(3, 32'h0, "leds_rst");
    rd(32'h40000108, 32'h0, "systick_rst");
    rd(32'h40000104, 32'h0, "disp_rst");
    rst_n = 1'b1;
    step(); step();

    // RAM, aliasing, unmapped, read-during-write
    wr(32'h00000010, 32'h12345678);
    rd(32'h00000010, 32'h12345678, "ram_rd");
    rd(32'h00000810, 32'h12345678, "ram_alias");
    rd(32'h40000200, 32'h0, "unmapped");
    rd(32'h40000020, 32'h0, "timer2_unmapped");
    addr = 32'h10; mem_en = 1'b0;
    push(0, 32'h0, "rd_disabled");
    step();
    wr_chk(32'h00000010, 32'h0BADF00D, 32'h12345678, "rdw_old");
    rd(32'h00000010, 32'h0BADF00D, "rdw_new");

    // LED and DISP registers
    wr(32'h40000100, 32'hFFFFFFFF);
    push(3, 32'h7F, "leds_o");
    rd(32'h40000100, 32'h7F, "led_rd");
    wr(32'h40000104, 32'hFFFF1A3F);
    rd(32'h40000104, 32'h1A3F, "disp_rd");

    // scan: sync on the first cycle of digit slot 0, then check 16 cycles
    wait_an(4'b0111, 1'b1, "scan_sync3");
    wait_an(4'b0111, 1'b0, "scan_sync0");
    step();
    for (int i = 1; i <= 16; i++) begin
      push(5, 32'(an_tab[(i / 4) % 4]), "scan_an");
      push(4, 32'(seg_tab[(i / 4) % 4]), "scan_seg");
      step();
    end

    // timer 0 reload
    wr(32'h40000000, 32'hFFFFFFF0);
    wr(32'h40000004, 32'hFFFFFFFE);
    wr(32'h40000008, 32'h3);
    rd(32'h40000004, 32'hFFFFFFFE, "tl_pre");
    push(1, 32'h0, "irq_pre");
    rd(32'h40000004, 32'hFFFFFFFF, "tl_max");
    push(1, 32'h1, "irq_reload");
    push(2, 32'h1, "irqvec_reload");
    rd(32'h40000004, 32'hFFFFFFF0, "tl_reload");
    rd(32'h40000008, 32'h7, "tcon_status");
    rd(32'h40000000, 32'hFFFFFFF0, "th_rd");
    wr(32'h40000008, 32'h4);
    push(1, 32'h0, "irq_clr");
    rd(32'h40000008, 32'h0, "tcon_clr");

    // W1C on the reload cycle: set wins; later clear works
    wr(32'h40000004, 32'hFFFFFFFE);
    wr(32'h40000008, 32'h3);
    rd(32'h40000004, 32'hFFFFFFFE, "tl_race_pre");
    wr(32'h40000008, 32'h7);
    push(1, 32'h1, "irq_race");
    rd(32'h40000008, 32'h7, "w1c_race");
    wr(32'h40000008, 32'h7);
    push(1, 32'h0, "irq_w1c");
    rd(32'h40000008, 32'h3, "w1c_clear");

    // TL write beats increment; run=0 holds
    wr(32'h40000004, 32'h100);
    rd(32'h40000004, 32'h100, "tl_wr_prio");
    rd(32'h40000004, 32'h101, "tl_inc");
    wr(32'h40000008, 32'h0);
    rd(32'h40000004, 32'h103, "tl_hold0");
    rd(32'h40000004, 32'h103, "tl_hold1");

    // timer 1 raises irq, then a half-cycle reset pulse
    wr(32'h40000010, 32'h0);
    wr(32'h40000014, 32'hFFFFFFFF);
    wr(32'h40000018, 32'h3);
    rd(32'h40000014, 32'hFFFFFFFF, "t1_max");
    push(1, 32'h1, "t1_irq");
    push(2, 32'h2, "t1_irqvec");
    rd(32'h40000014, 32'h0, "t1_reload");
    rd(32'h40000014, 32'h1, "t1_run");

    rst_n = 1'b0; mem_en = 1'b1; addr = 32'h40000014;
    push(0, 32'h0, "rst_tl1");
    push(1, 32'h0, "rst_irq");
    push(2, 32'h0, "rst_irqvec");
    push(3, 32'h0, "rst_leds");
    @(negedge clk); #1;
    rst_n = 1'b1; mem_en = 1'b0;
    step();
    wr(32'h40000014, 32'h5);
    rst_n = 1'b0; mem_en = 1'b1; addr = 32'h40000108;
    push(0, 32'h0, "rst_systick");
    @(negedge clk); #1;
    rst_n = 1'b1; mem_en = 1'b0;
    step();
    rd(32'h00000010, 32'h0BADF00D, "ram_retained");
    rd(32'h40000018, 32'h0, "t1_tcon_rst");

    step(); step();
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL queue_drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
